// File: rtl/stm_trace_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : stm_trace_event_tx
// Purpose  : STM software-trace transmitter. Watches one core's retire /
//            writeback trace port, keeps a shadow copy of GPR r3, and turns
//            every retired `l.nop K` (K != 0) into a timestamped event
//            {id, value, timestamp, lost} queued in a small first-word-
//            fall-through FIFO with a valid/ready output.
// Ports    : clk, rst_sys_n          clock, async active-low reset
//            trace_*                 core retire/writeback trace port
//            out_valid/out_ready     event handshake toward interconnect
//            out_id/value/timestamp/lost   head-of-FIFO event fields
//            overflow_count          saturating count of dropped events
//            r3_shadow               current shadow r3 (debug visibility)
// Revision : 1.0 - initial release
// ============================================================================
module stm_trace_event_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_sys_n,
  input  logic                 trace_enable,
  input  logic [31:0]          trace_insn,
  input  logic                 trace_wben,
  input  logic [4:0]           trace_wbreg,
  input  logic [31:0]          trace_wbdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_id,
  output logic [31:0]          out_value,
  output logic [31:0]          out_timestamp,
  output logic                 out_lost,
  output logic [OVF_WIDTH-1:0] overflow_count,
  output logic [31:0]          r3_shadow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 16 + 32 + 32 + 1;

  // Entry layout: {id, value, timestamp, lost}
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [31:0]          ts_q, ts_d;
  logic [31:0]          r3_q, r3_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic                 lost_pend_q, lost_pend_d;

  logic                 trig;
  logic                 wb_r3;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [31:0]          ev_value;
  logic [EW-1:0]        new_entry;
  logic                 unused_insn_bits;

  // Bits 23:16 of the nop encoding carry no event information.
  assign unused_insn_bits = ^trace_insn[23:16];

  assign trig  = trace_enable && (trace_insn[31:24] == 8'h15) && (trace_insn[15:0] != 16'h0000);
  assign wb_r3 = trace_enable && trace_wben && (trace_wbreg == 5'd3);

  // A writeback to r3 retiring alongside the nop is forwarded so the event
  // sees the architecturally current r3.
  assign ev_value = wb_r3 ? trace_wbdata : r3_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = !fifo_empty && out_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can still land.
  assign push = trig && (!fifo_full || pop);
  assign drop = trig && !push;

  assign new_entry = {trace_insn[15:0], ev_value, ts_q, lost_pend_q};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ts_d        = ts_q + 32'd1;
    r3_d        = r3_q;
    ovf_d       = ovf_q;
    lost_pend_d = lost_pend_q;

    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    if (wb_r3) r3_d = trace_wbdata;

    if (drop) begin
      lost_pend_d = 1'b1;
      if (ovf_q != {OVF_WIDTH{1'b1}}) ovf_d = ovf_q + OVF_WIDTH'(1);
    end else if (push) begin
      lost_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ts_q        <= '0;
      r3_q        <= '0;
      ovf_q       <= '0;
      lost_pend_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ts_q        <= ts_d;
      r3_q        <= r3_d;
      ovf_q       <= ovf_d;
      lost_pend_q <= lost_pend_d;
    end
  end

  // Storage is cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end
  end

  assign out_valid = !fifo_empty;
  assign {out_id, out_value, out_timestamp, out_lost} = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_count = ovf_q;
  assign r3_shadow      = r3_q;

endmodule
`default_nettype wire

// File: tb/tb_stm_trace_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_stm_trace_event_tx
// Purpose  : Self-checking bench for stm_trace_event_tx. Stimulus pushes the
//            expected events into a queue; a negedge monitor pops and
//            compares each handshaken event and checks head stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stm_trace_event_tx;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] value;
    logic [31:0] ts;
    logic        lost;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        trace_enable = 1'b0;
  logic [31:0] trace_insn = '0;
  logic        trace_wben = 1'b0;
  logic [4:0]  trace_wbreg = '0;
  logic [31:0] trace_wbdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_id;
  logic [31:0] out_value;
  logic [31:0] out_timestamp;
  logic        out_lost;
  logic [15:0] overflow_count;
  logic [31:0] r3_shadow;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  ev_t exp_q[$];
  ev_t held;
  bit  held_valid = 0;

  stm_trace_event_tx #(.FIFO_DEPTH(4), .OVF_WIDTH(16)) dut (
    .clk(clk), .rst_sys_n(rst_sys_n),
    .trace_enable(trace_enable), .trace_insn(trace_insn),
    .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_value(out_value), .out_timestamp(out_timestamp), .out_lost(out_lost),
    .overflow_count(overflow_count), .r3_shadow(r3_shadow)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT timestamp in that cycle.
  always @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) tb_cyc <= 0;
    else            tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t head;
    head = '{id: out_id, value: out_value, ts: out_timestamp, lost: out_lost};
    if (!rst_sys_n) begin
      exp_q.delete();
      held_valid = 0;
    end else if (out_valid) begin
      if (held_valid) check("head_stable", 128'(head), 128'(held));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 128'(head), 128'(0));
        end else begin
          check("event", 128'(head), 128'(exp_q.pop_front()));
        end
        held_valid = 0;
      end else begin
        held = head;
        held_valid = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_sys_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_sys_n = 1'b1;
    #1;
  endtask

  // Retire `l.nop id` this cycle; record expectation if it should be queued.
  task automatic fire(input logic [15:0] id, input logic [31:0] v,
                      input logic [31:0] ts, input logic lost, input bit accept);
    trace_enable = 1'b1;
    trace_insn   = {8'h15, 8'h00, id};
    if (accept) exp_q.push_back('{id: id, value: v, ts: ts, lost: lost});
    step();
    trace_enable = 1'b0;
    trace_insn   = '0;
    trace_wben   = 1'b0;
    trace_wbreg  = '0;
    trace_wbdata = '0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check("drain_done", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    // ---- reset and idle ----
    do_reset();
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_ovf", 128'(overflow_count), 128'(0));
    check("rst_r3", 128'(r3_shadow), 128'(0));
    check("rst_head", 128'({out_id, out_value, out_timestamp, out_lost}), 128'(0));
    out_ready = 1'b1;
    repeat (10) step();
    fire(16'h0001, 32'h0, 32'd10, 1'b0, 1);
    drain(5);

    // ---- reset mid-operation discards queued events ----
    out_ready = 1'b0;
    fire(16'h0002, 32'h0, 32'(tb_cyc), 1'b0, 1);
    fire(16'h0003, 32'h0, 32'(tb_cyc), 1'b0, 1);
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    do_reset();
    check("midrst_valid", 128'(out_valid), 128'(0));

    // ---- basic event ----
    out_ready = 1'b1;
    repeat (3) step();
    trace_enable = 1'b1; trace_wben = 1'b1; trace_wbreg = 5'd3; trace_wbdata = 32'hDEADBEEF;
    step();
    trace_enable = 1'b0; trace_wben = 1'b0; trace_wbreg = '0; trace_wbdata = '0;
    step();
    fire(16'h0020, 32'hDEADBEEF, 32'd5, 1'b0, 1);
    check("basic_latency", 128'(out_valid), 128'(1));
    step();
    check("basic_popped", 128'(out_valid), 128'(0));

    // ---- filtering ----
    trace_enable = 1'b1; trace_insn = 32'h15000000;
    step();
    trace_insn = 32'h14000005;
    step();
    trace_enable = 1'b0; trace_insn = '0;
    check("nop0_no_event", 128'(out_valid), 128'(0));
    trace_enable = 1'b1; trace_wben = 1'b1; trace_wbreg = 5'd4; trace_wbdata = 32'h1234;
    step();
    check("wb_r4_ignored", 128'(r3_shadow), 128'(32'hDEADBEEF));
    trace_enable = 1'b0; trace_wbreg = 5'd3; trace_wbdata = 32'hCAFE;
    step();
    trace_wben = 1'b0; trace_wbreg = '0; trace_wbdata = '0;
    check("wb_noenable_ignored", 128'(r3_shadow), 128'(32'hDEADBEEF));

    // ---- same-cycle forward ----
    trace_wben = 1'b1; trace_wbreg = 5'd3; trace_wbdata = 32'h55;
    fire(16'h0007, 32'h55, 32'(tb_cyc), 1'b0, 1);
    check("fwd_r3", 128'(r3_shadow), 128'(32'h55));
    drain(5);

    // ---- overflow ----
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) fire(16'(k), 32'h0, 32'(tb_cyc), 1'b0, k <= 4);
    check("ovf_count2", 128'(overflow_count), 128'(2));
    out_ready = 1'b1;
    fire(16'h0007, 32'h0, 32'(tb_cyc), 1'b1, 1);
    check("ovf_after_fullpop", 128'(overflow_count), 128'(2));
    drain(20);

    // ---- full with simultaneous pop, then backpressure ----
    out_ready = 1'b0;
    for (int k = 'h11; k <= 'h14; k++) fire(16'(k), 32'h0, 32'(tb_cyc), 1'b0, 1);
    out_ready = 1'b1;
    fire(16'h0009, 32'h0, 32'(tb_cyc), 1'b0, 1);
    out_ready = 1'b0;
    check("fullpop_ovf", 128'(overflow_count), 128'(2));
    fire(16'h000A, 32'h0, 32'(tb_cyc), 1'b0, 0);
    check("still_full_drop", 128'(overflow_count), 128'(3));
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      step();
    end
    out_ready = 1'b1;
    drain(20);
    step();
    check("final_idle", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/stm_trace_event_tx.md
Name: stm_trace_event_tx

Overview:
- Transmit side of the software trace (STM) channel. Sits beside each compute tile core and watches that core's retire/writeback trace port: enable, instruction word, writeback enable, writeback register, writeback data.
- Keeps a shadow copy of GPR r3.
- When an `l.nop K` instruction with K≠0 retires, it emits an event {id=K, value=r3, timestamp, lost flag} through a small FIFO with a valid/ready output toward the debug interconnect.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two ≥2.
- OVF_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock
- rst_sys_n  input  1  asynchronous active-low reset
- trace_enable  input  1  instruction retired this cycle
- trace_insn  input  32  retired instruction word
- trace_wben  input  1  writeback valid with this retire
- trace_wbreg  input  5  writeback register index
- trace_wbdata  input  32  writeback data
- out_valid  output  1  event available at FIFO head
- out_ready  input  1  consumer accepts head event
- out_id  output  16  event id (K field of `l.nop K`)
- out_value  output  32  r3 value at event time
- out_timestamp  output  32  cycle counter at trigger cycle
- out_lost  output  1  one or more events dropped immediately before this one
- overflow_count  output  OVF_WIDTH  total dropped events, saturating
- r3_shadow  output  32  current shadow r3 (debug visibility)

Behaviour:
- Reset: one clock; rst_sys_n is asynchronous, active-low. While it is low, all of the following are 0: registers, FIFO pointers, timestamp, r3_shadow, overflow_count, pending-lost flag, out_valid. out_id, out_value, out_timestamp and out_lost read 0 while the FIFO is empty after reset.
- Reset mid-operation: queued events are discarded and no partial handshake survives.
- Timestamp: free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. It starts at 0 in the first cycle after reset release.
- Shadow r3 update: in any cycle with trace_enable && trace_wben && trace_wbreg==3, r3_shadow <= trace_wbdata on that edge. Writebacks with trace_enable=0 are ignored.
- Trigger condition: trace_enable && trace_insn[31:24]==8'h15 && trace_insn[15:0]!=0.
  - id = trace_insn[15:0].
  - `l.nop 0` never triggers.
- Trigger value:
  - Normally value = r3_shadow.
  - If the same cycle also carries a writeback to r3, value = trace_wbdata (forwarded).
  - timestamp = counter value in the trigger cycle.
- Push accept rule: a push is accepted if FIFO not full, or if full and a pop occurs in the same cycle (out_valid && out_ready).
- Dropped push:
  - the event is discarded;
  - overflow_count increments, saturating at all-ones;
  - the pending-lost flag is set.
- Accepted push: out_lost for the entry = pending-lost flag; the flag then clears.
  - A drop and an accept cannot share a cycle (max one trigger per cycle).
- Output, first-word-fall-through:
  - out_valid = FIFO not empty; out_* always show the head entry.
  - Latency: trigger in cycle N → out_valid=1 with the event in cycle N+1 if the FIFO was empty.
  - Pop occurs when out_valid && out_ready on the clock edge. Head data must stay stable while out_valid && !out_ready.
  - out_ready with an empty FIFO has no effect.
- Simultaneous push and pop with FIFO empty: no pop. The push lands and is visible next cycle.
- Pointers: wrap modulo FIFO_DEPTH. Use an extra MSB (or occupancy counter) to distinguish full from empty.
- out_valid is a registered function of FIFO state only. It does not depend combinationally on out_ready.

Test Plan:
- Reset and idle: hold rst_sys_n low 5 cycles, release, idle 10 cycles → out_valid=0, overflow_count=0, r3_shadow=0, timestamp advances to 10.
- Basic event:
  - retire writeback r3=0xDEADBEEF at cycle 3, then `l.nop 0x0020` (insn 0x15000020) at cycle 5, out_ready=1;
  - → cycle 6: out_valid=1, out_id=0x0020, out_value=0xDEADBEEF, out_timestamp=5, out_lost=0; popped that cycle.
- Filtering:
  - insn 0x15000000 → no event;
  - writeback to r4=0x1234 → r3_shadow unchanged;
  - trace_wben=1 with trace_enable=0, wbreg=3 → r3_shadow unchanged.
- Same-cycle forward: writeback r3=0x55 together with insn 0x15000007 → event id=7, value=0x55; r3_shadow=0x55 afterwards.
- Overflow (FIFO_DEPTH=4):
  - out_ready=0; 6 triggers with ids 1..6 → FIFO holds ids 1..4, overflow_count=2;
  - then out_ready=1 and trigger id 7 → drains 1,2,3,4 (all out_lost=0), then id 7 with out_lost=1.
- Full with simultaneous pop and backpressure:
  - FIFO full, out_ready=1 and trigger id 9 in the same cycle → push accepted, overflow_count unchanged, occupancy stays 4;
  - out_ready toggled 0/1 every cycle → head fields stable while stalled, ids emerge in order.
